spi_master_ctrl_p: RTL and testbench
====================================

Name: spi_master_ctrl_p

Overview:
Parametrised SPI master transaction engine, the successor to the fixed 32-bit SPI master control FSM.
- Adds run-time CPOL/CPHA mode, MSB/LSB-first order, chip-select framing, a start/busy/done handshake and a generic data width.
- Sits between a register/CPU interface and the pad-level SPI signals. Runs one full-duplex transfer per start pulse.

Parameters:
DATA_W, 32, maximum bits per transfer; tx_data/rx_data width
LEN_W, 6, width of len; must satisfy 2**LEN_W >= DATA_W
DIV_W, 4, width of period (half-period divider)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; accepted only when busy=0
len  in  LEN_W  bits-1 (0..DATA_W-1); values >= DATA_W clamp to DATA_W-1
period  in  DIV_W  half-period = period+1 clk cycles
cpol  in  1  SPI_CLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  bit order
tx_data  in  DATA_W  transmit word, right-aligned in [len:0]
rx_data  out  DATA_W  received word, right-aligned; bits above len are zero
busy  out  1  high from the cycle after start acceptance until DONE exits
done  out  1  one-cycle pulse at end of transfer
SPI_CLK  out  1  serial clock (registered)
SPI_MO  out  1  master out (registered)
SPI_MI  in  1  master in; registered once internally (mi_q)
SPI_CS_N  out  1  chip select, active-low (registered)

Behaviour:
- Reset (async, immediate): SPI_CLK=0, SPI_MO=0, SPI_CS_N=1, busy=0, done=0, rx_data=0, FSM=IDLE, counters=0.
- On the start cycle (IDLE, start=1), latch tx_data, len (clamped), period, cpol, cpha and lsb_first into shadow registers. Inputs may change afterwards.
- start while busy=1 is ignored.
- Half-period timer counts 0..period_q. A "tick" is the cycle where count==period_q; the counter then restarts at 0.
- States:
  - IDLE: SPI_CLK=cpol (live input), CS_N=1. start -> SETUP.
  - SETUP: CS_N=0, SPI_CLK=cpol_q, MO=bit 0. tick -> LEAD.
  - LEAD: SPI_CLK=~cpol_q. tick -> TRAIL.
  - TRAIL: SPI_CLK=cpol_q. tick with bit_cnt==len_q -> HOLD; otherwise bit_cnt+1 and -> LEAD.
  - HOLD: CS_N=0, SPI_CLK=cpol_q. tick -> DONE.
  - DONE: CS_N=1, done=1, rx_data updated, busy=0 on the next cycle. Always -> IDLE.
- Bit mapping: transfer bit i uses index (lsb_first_q ? i : len_q-i) for both the tx fetch and the rx store.
- CPHA=0:
  - MO presents bit 0 in SETUP and changes to bit i+1 on entry to the next LEAD.
  - mi_q is captured into bit i at the LEAD tick.
- CPHA=1:
  - MO changes to bit i on entry to LEAD i.
  - mi_q is captured into bit i at the TRAIL tick.
- Transfer length: start cycle to done pulse = (2*(len+1)+2)*(period+1) + 1 clk cycles.
- rx shift register clears on start acceptance. rx_data holds its value between transfers.
- Illegal FSM encoding -> IDLE with CS_N=1.
- Reset mid-transfer: CS_N goes high immediately and no done pulse is generated.

Optional Feature:
Macro SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port loop (1 bit), latched at start. When loop_q=1, the receive path samples the internal registered MO instead of mi_q; SPI_MO and SPI_CLK still toggle normally.
- Undefined: the port is absent and behaviour is identical to loop=0.

Decomposition:
- Package spi_master_pkg holds:
  - state enum (IDLE, SETUP, LEAD, TRAIL, HOLD, DONE) with a 3-bit encoding;
  - mode constants CPOL0/CPOL1/CPHA0/CPHA1;
  - a function returning the bit index from (i, len, lsb_first).
- One sub-module, spi_half_period_timer (DIV_W counter with clear/enable, tick output), is instantiated once.

Test Plan:
- DATA_W=32, len=7, period=1, cpol=0, cpha=0, msb-first, tx=0xA5, SPI_MI tied to SPI_MO -> rx_data=0x000000A5; done at cycle 37 after start; 8 SPI_CLK rising edges.
- len=31, period=0, cpol=1, cpha=1, lsb_first=1, tx=0x12345678, SPI_MI driven by a slave model returning 0xDEADBEEF LSB-first -> rx_data=0xDEADBEEF; SPI_CLK idles high; CS_N low for exactly 66 cycles.
- start asserted again during a transfer (len=3) -> ignored; exactly one done pulse; busy stays continuously high.
- rst asserted mid-LEAD at bit 4 -> next edge: CS_N=1, busy=0, SPI_CLK=0, no done; a subsequent start (len=0) completes normally.
- len=40 with DATA_W=32 -> clamped to 31; 32 clocks are generated and rx_data bits [31:0] are valid.
- With SPI_MASTER_LOOPBACK_EN defined, loop=1, SPI_MI held at 0, tx=0x3C, len=7 -> rx_data=0x3C; with loop=0 -> rx_data=0x00.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types, mode constants and the bit-order helper for the SPI master transaction engine.
package spi_master_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StLead  = 3'd2,
        StTrail = 3'd3,
        StHold  = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic CPOL0 = 1'b0;
    localparam logic CPOL1 = 1'b1;
    localparam logic CPHA0 = 1'b0;
    localparam logic CPHA1 = 1'b1;

    // Word index touched by transfer bit i, for both the tx fetch and the rx store.
    function automatic logic [31:0] bit_index(input logic [31:0] i, input logic [31:0] len,
                                              input logic lsb_first);
        return lsb_first ? i : len - i;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_p_if.sv
// Register-side request/response bundle of the SPI master; the optional loop input exists only
// when SPI_MASTER_LOOPBACK_EN is defined.
interface spi_master_ctrl_p_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned DIV_W  = 4
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DIV_W-1:0]  period;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic              loop;

    modport master (output start, len, period, cpol, cpha, lsb_first, tx_data, loop,
                    input rx_data, busy, done);
    modport slave  (input start, len, period, cpol, cpha, lsb_first, tx_data, loop,
                    output rx_data, busy, done);
`else
    modport master (output start, len, period, cpol, cpha, lsb_first, tx_data,
                    input rx_data, busy, done);
    modport slave  (input start, len, period, cpol, cpha, lsb_first, tx_data,
                    output rx_data, busy, done);
`endif
endinterface

// File: rtl/spi_half_period_timer.sv
// Half-period timer: counts 0..period while enabled and pulses tick on the terminal count.
module spi_half_period_timer #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] count_q;

    assign tick = en && (count_q == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr || tick) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + DIV_W'(1);
        end
    end
endmodule

// File: rtl/spi_master_ctrl_p.sv
// SPI master transaction engine: one full-duplex transfer per accepted start pulse.
// Define SPI_MASTER_LOOPBACK_EN to add the internal MO->receive loopback (ctrl.loop).
module spi_master_ctrl_p
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned DIV_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_p_if.slave ctrl,
    output logic               SPI_CLK,
    output logic               SPI_MO,
    input  logic               SPI_MI,
    output logic               SPI_CS_N
);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, rx_sh_q, rx_data_q;
    logic [LEN_W-1:0]  len_q, bit_cnt_q, len_clamp;
    logic [DIV_W-1:0]  period_q;
    logic              cpol_q, cpha_q, lsb_q, mi_q, clk_q, mo_q, cs_n_q;
    logic              clk_d, cs_n_d, tick, tmr_clr, tmr_en, start_acc, last_bit, capture, rx_bit;
    logic [IDX_W-1:0]  idx_first, idx_next, idx_cur;

    assign start_acc = (state_q == StIdle) && ctrl.start;
    assign tmr_clr   = (state_q == StIdle) || (state_q == StDone);
    assign tmr_en    = !tmr_clr;
    assign last_bit  = (bit_cnt_q == len_q);
    assign len_clamp = (32'(ctrl.len) >= DATA_W) ? LEN_W'(DATA_W - 1) : ctrl.len;

    assign idx_first = IDX_W'(bit_index(32'd0, 32'(len_clamp), ctrl.lsb_first));
    assign idx_next  = IDX_W'(bit_index(32'(bit_cnt_q) + 32'd1, 32'(len_q), lsb_q));
    assign idx_cur   = IDX_W'(bit_index(32'(bit_cnt_q), 32'(len_q), lsb_q));

    assign capture = tick && (((state_q == StLead) && (cpha_q == CPHA0)) ||
                              ((state_q == StTrail) && (cpha_q == CPHA1)));

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_q <= 1'b0;
        end else if (start_acc) begin
            loop_q <= ctrl.loop;
        end
    end

    assign rx_bit = loop_q ? mo_q : mi_q;
`else
    assign rx_bit = mi_q;
`endif

    spi_half_period_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .period(period_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = 1'b1;
        clk_d   = cpol_q;
        case (state_q)
            StIdle:  if (ctrl.start) state_d = StSetup;
            StSetup: if (tick) state_d = StLead;
            StLead:  if (tick) state_d = StTrail;
            StTrail: if (tick) state_d = last_bit ? StHold : StLead;
            StHold:  if (tick) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Pad outputs are registered from the next state so they line up with the FSM.
        cs_n_d = (state_d == StIdle) || (state_d == StDone);
        if (state_d == StLead) begin
            clk_d = ~cpol_q;
        end else if ((state_q == StIdle) || (state_d == StIdle)) begin
            clk_d = ctrl.cpol;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            period_q  <= '0;
            cpol_q    <= CPOL0;
            cpha_q    <= CPHA0;
            lsb_q     <= 1'b0;
            mi_q      <= 1'b0;
            clk_q     <= CPOL0;
            mo_q      <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            mi_q   <= SPI_MI;
            clk_q  <= clk_d;
            cs_n_q <= cs_n_d;
            if (start_acc) begin
                tx_q      <= ctrl.tx_data;
                len_q     <= len_clamp;
                period_q  <= ctrl.period;
                cpol_q    <= ctrl.cpol;
                cpha_q    <= ctrl.cpha;
                lsb_q     <= ctrl.lsb_first;
                bit_cnt_q <= '0;
                rx_sh_q   <= '0;
                mo_q      <= ctrl.tx_data[idx_first];
            end
            // MO advances on entry to the next LEAD.
            if ((state_q == StTrail) && tick && !last_bit) begin
                bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                mo_q      <= tx_q[idx_next];
            end
            if (capture) begin
                rx_sh_q[idx_cur] <= rx_bit;
            end
            if ((state_q == StHold) && tick) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end

    assign ctrl.busy    = (state_q != StIdle);
    assign ctrl.done    = (state_q == StDone);
    assign ctrl.rx_data = rx_data_q;
    assign SPI_CLK      = clk_q;
    assign SPI_MO       = mo_q;
    assign SPI_CS_N     = cs_n_q;
endmodule

// File: tb/tb_spi_master_ctrl_p.sv
// Self-checking bench for spi_master_ctrl_p: slave model on the pads plus a transfer-level model.
module tb_spi_master_ctrl_p;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DIV_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk, spi_mo, spi_cs_n, spi_mi, slave_mi;
    int   mi_mode;  // 0: slave model, 1: MI tied to MO, 2: MI held low

    spi_master_ctrl_p_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) ctrl ();

    spi_master_ctrl_p #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .SPI_CLK (spi_clk),
        .SPI_MO  (spi_mo),
        .SPI_MI  (spi_mi),
        .SPI_CS_N(spi_cs_n)
    );

    assign spi_mi = (mi_mode == 1) ? spi_mo : (mi_mode == 2) ? 1'b0 : slave_mi;

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          obs_lat, obs_rise, obs_trail, obs_cs_low, obs_done;
    logic [31:0] obs_rx, obs_mo;
    logic        obs_busy_gap, obs_post_busy;

    function automatic int clamp_len(input int l);
        return (l >= 32) ? 31 : l;
    endfunction

    function automatic logic [31:0] mask_of(input int l);
        logic [63:0] m;
        m = (64'd1 << (l + 1)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic int xfer_cycles(input int l, input int per);
        return (2 * (l + 1) + 2) * (per + 1) + 1;
    endfunction

    // Word position of the k-th bit on the wire.
    function automatic int wire_pos(input int k, input int l, input logic lsb);
        return lsb ? k : l - k;
    endfunction

    // Runs one transfer; the slave model answers with sw and records what MO carried.
    task automatic do_xfer(input logic [31:0] tx, input int len_in, input int per, input logic pol,
                           input logic pha, input logic lsb, input logic lp,
                           input logic [31:0] sw, input int restart_at, input int abort_at);
        int   l, nxt, ntr, seen_at;
        logic prev_cs, prev_sclk;
        l = clamp_len(len_in);
        obs_lat = -1; obs_rise = 0; obs_trail = 0; obs_cs_low = 0; obs_done = 0;
        obs_rx = 'x; obs_mo = '0; obs_busy_gap = 1'b0;
        nxt = 0; ntr = 0; seen_at = -1;
        @(negedge clk);
        ctrl.tx_data   = tx;
        ctrl.len       = LEN_W'(len_in);
        ctrl.period    = DIV_W'(per);
        ctrl.cpol      = pol;
        ctrl.cpha      = pha;
        ctrl.lsb_first = lsb;
`ifdef SPI_MASTER_LOOPBACK_EN
        ctrl.loop      = lp;
`endif
        ctrl.start     = 1'b1;
        prev_cs   = spi_cs_n;
        prev_sclk = spi_clk;
        @(posedge clk);
        #1;
        ctrl.start     = 1'b0;
        ctrl.tx_data   = $urandom();
        ctrl.len       = LEN_W'($urandom_range(0, 63));
        ctrl.period    = DIV_W'($urandom_range(0, 15));
        ctrl.cpha      = 1'($urandom_range(0, 1));
        ctrl.lsb_first = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) return;
            if (restart_at > 0 && cyc == restart_at) ctrl.start = 1'b1;
            if (restart_at > 0 && cyc == restart_at + 1) ctrl.start = 1'b0;
            if (seen_at < 0 && ctrl.busy !== 1'b1) obs_busy_gap = 1'b1;
            if (spi_cs_n === 1'b0) begin
                obs_cs_low++;
                if (prev_cs === 1'b1) begin
                    nxt = 0;
                    if (!pha) begin
                        slave_mi = sw[wire_pos(0, l, lsb)];
                        nxt = 1;
                    end
                end else if (spi_clk !== prev_sclk) begin
                    if (spi_clk === 1'b1) obs_rise++;
                    if (spi_clk !== pol) begin
                        if (pha && nxt <= l) begin
                            slave_mi = sw[wire_pos(nxt, l, lsb)];
                            nxt++;
                        end
                    end else begin
                        if (ntr <= l) obs_mo[wire_pos(ntr, l, lsb)] = spi_mo;
                        ntr++;
                        obs_trail++;
                        if (!pha && nxt <= l) begin
                            slave_mi = sw[wire_pos(nxt, l, lsb)];
                            nxt++;
                        end
                    end
                end
            end
            if (ctrl.done === 1'b1) begin
                obs_done++;
                if (seen_at < 0) begin
                    seen_at = cyc;
                    obs_lat = cyc;
                    obs_rx  = ctrl.rx_data;
                end
            end
            prev_cs   = spi_cs_n;
            prev_sclk = spi_clk;
            if (seen_at >= 0 && cyc >= seen_at + 3) break;
        end
        obs_post_busy = ctrl.busy;
    endtask

    task automatic test_reset();
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
        n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", spi_clk); end
        n_checks++; if (spi_mo !== 1'b0) begin n_fail++; $display("FAIL reset_mo: got %b expected 0", spi_mo); end
        n_checks++; if (ctrl.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ctrl.busy); end
        n_checks++; if (ctrl.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", ctrl.done); end
        n_checks++; if (ctrl.rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx: got %h expected 0", ctrl.rx_data); end
    endtask

    task automatic test_basic();
        mi_mode = 1;
        do_xfer(32'h0000_00A5, 7, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
        n_checks++; if (obs_rx !== 32'h0000_00A5) begin n_fail++; $display("FAIL basic_rx: got %h expected 000000a5", obs_rx); end
        n_checks++; if (obs_lat !== 37) begin n_fail++; $display("FAIL basic_latency: got %0d expected 37", obs_lat); end
        n_checks++; if (obs_rise !== 8) begin n_fail++; $display("FAIL basic_rises: got %0d expected 8", obs_rise); end
        n_checks++; if (obs_mo !== 32'h0000_00A5) begin n_fail++; $display("FAIL basic_mo: got %h expected 000000a5", obs_mo); end
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", obs_done); end
    endtask

    task automatic test_slave_lsb_mode3();
        mi_mode = 0;
        do_xfer(32'h1234_5678, 31, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 0);
        n_checks++; if (obs_rx !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mode3_rx: got %h expected deadbeef", obs_rx); end
        n_checks++; if (obs_cs_low !== 66) begin n_fail++; $display("FAIL mode3_cs_low: got %0d expected 66", obs_cs_low); end
        n_checks++; if (obs_mo !== 32'h1234_5678) begin n_fail++; $display("FAIL mode3_mo: got %h expected 12345678", obs_mo); end
        n_checks++; if (spi_clk !== 1'b1) begin n_fail++; $display("FAIL mode3_idle_sclk: got %b expected 1", spi_clk); end
        n_checks++; if (obs_lat !== 67) begin n_fail++; $display("FAIL mode3_latency: got %0d expected 67", obs_lat); end
    endtask

    task automatic test_start_while_busy();
        mi_mode = 1;
        do_xfer(32'h0000_0009, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5, 0);
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", obs_done); end
        n_checks++; if (obs_busy_gap !== 1'b0) begin n_fail++; $display("FAIL busy_start_gap: got %b expected 0", obs_busy_gap); end
        n_checks++; if (obs_rx !== 32'h9) begin n_fail++; $display("FAIL busy_start_rx: got %h expected 9", obs_rx); end
        n_checks++; if (obs_lat !== xfer_cycles(3, 1)) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", obs_lat, xfer_cycles(3, 1)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] sw;
        mi_mode = 0;
        do_xfer(32'hFFFF_FFFF, 7, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55, 0, 20);
        rst = 1'b1;
        #1;
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_cs_n: got %b expected 1", spi_cs_n); end
        n_checks++; if (ctrl.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", ctrl.busy); end
        n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b expected 0", spi_clk); end
        @(posedge clk);
        #1;
        n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL midrst_edge_cs_n: got %b expected 1", spi_cs_n); end
        n_checks++; if (ctrl.done !== 1'b0) begin n_fail++; $display("FAIL midrst_edge_done: got %b expected 0", ctrl.done); end
        @(negedge clk);
        rst = 1'b0;
        sw = $urandom();
        do_xfer(32'h1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, sw, 0, 0);
        n_checks++; if (obs_lat !== 5) begin n_fail++; $display("FAIL midrst_after_latency: got %0d expected 5", obs_lat); end
        n_checks++; if (obs_rx !== (sw & 32'h1)) begin n_fail++; $display("FAIL midrst_after_rx: got %h expected %h", obs_rx, sw & 32'h1); end
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL midrst_after_done_count: got %0d expected 1", obs_done); end
    endtask

    task automatic test_len_clamp();
        logic [31:0] sw;
        mi_mode = 0;
        sw = $urandom();
        do_xfer(32'hCAFE_F00D, 40, 0, 1'b0, 1'b1, 1'b0, 1'b0, sw, 0, 0);
        n_checks++; if (obs_rise !== 32) begin n_fail++; $display("FAIL clamp_rises: got %0d expected 32", obs_rise); end
        n_checks++; if (obs_trail !== 32) begin n_fail++; $display("FAIL clamp_trails: got %0d expected 32", obs_trail); end
        n_checks++; if (obs_rx !== sw) begin n_fail++; $display("FAIL clamp_rx: got %h expected %h", obs_rx, sw); end
        n_checks++; if (obs_lat !== 67) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 67", obs_lat); end
    endtask

    task automatic test_random();
        logic [31:0] tx, sw, m;
        int          len_in, per, l;
        logic        pol, pha, lsb;
        mi_mode = 0;
        for (int n = 0; n < 12; n++) begin
            tx = $urandom(); sw = $urandom();
            len_in = $urandom_range(0, 47); per = $urandom_range(0, 3);
            pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            l = clamp_len(len_in);
            m = mask_of(l);
            do_xfer(tx, len_in, per, pol, pha, lsb, 1'b0, sw, 0, 0);
            n_checks++; if (obs_rx !== (sw & m)) begin n_fail++; $display("FAIL rand%0d_rx: got %h expected %h", n, obs_rx, sw & m); end
            n_checks++; if (obs_mo !== (tx & m)) begin n_fail++; $display("FAIL rand%0d_mo: got %h expected %h", n, obs_mo, tx & m); end
            n_checks++; if (obs_lat !== xfer_cycles(l, per)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, obs_lat, xfer_cycles(l, per)); end
            n_checks++; if (obs_rise !== l + 1) begin n_fail++; $display("FAIL rand%0d_rises: got %0d expected %0d", n, obs_rise, l + 1); end
            n_checks++; if (obs_post_busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_post_busy: got %b expected 0", n, obs_post_busy); end
        end
    endtask

    task automatic test_loopback();
        mi_mode = 2;
`ifdef SPI_MASTER_LOOPBACK_EN
        do_xfer(32'h0000_003C, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
        n_checks++; if (obs_rx !== 32'h3C) begin n_fail++; $display("FAIL loop_on_rx: got %h expected 3c", obs_rx); end
`endif
        do_xfer(32'h0000_003C, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
        n_checks++; if (obs_rx !== 32'h0) begin n_fail++; $display("FAIL loop_off_rx: got %h expected 0", obs_rx); end
        n_checks++; if (obs_mo !== 32'h3C) begin n_fail++; $display("FAIL loop_off_mo: got %h expected 3c", obs_mo); end
    endtask

    initial begin
        mi_mode        = 0;
        slave_mi       = 1'b0;
        ctrl.start     = 1'b0;
        ctrl.len       = '0;
        ctrl.period    = '0;
        ctrl.cpol      = 1'b0;
        ctrl.cpha      = 1'b0;
        ctrl.lsb_first = 1'b0;
        ctrl.tx_data   = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
        ctrl.loop      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic();
        test_slave_lsb_mode3();
        test_start_while_busy();
        test_reset_mid();
        test_len_clamp();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
